// File: rtl/led_mode_scheduler_pkg.sv
// Shared types, constants and pattern-stepping helpers for the LED mode scheduler.
// Patterns are defined for a 4-LED bank only.
package led_pkg;

    localparam int LED_W = 4;

    typedef enum logic [1:0] {
        MODE_FLOW_UP   = 2'd0,
        MODE_FLOW_DOWN = 2'd1,
        MODE_BLINK     = 2'd2,
        MODE_PINGPONG  = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    typedef logic [LED_W-1:0] led_t;

    localparam led_t INIT_FLOW_UP   = 4'b0001;
    localparam led_t INIT_FLOW_DOWN = 4'b1000;
    localparam led_t INIT_BLINK     = 4'b1111;
    localparam led_t INIT_PINGPONG  = 4'b0001;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    typedef struct packed {
        led_t led;
        logic dir;
    } step_t;

    function automatic led_t init_pattern(mode_t mode);
        case (mode)
            MODE_FLOW_UP:   return INIT_FLOW_UP;
            MODE_FLOW_DOWN: return INIT_FLOW_DOWN;
            MODE_BLINK:     return INIT_BLINK;
            default:        return INIT_PINGPONG;
        endcase
    endfunction

    function automatic logic is_one_hot(led_t v);
        return (v != '0) && ((v & (v - led_t'(1))) == '0);
    endfunction

    // Corrupted (non one-hot) values in the shifting modes snap back to the start pattern.
    function automatic step_t next_pattern(mode_t mode, led_t led, logic dir);
        step_t r;
        r.led = led;
        r.dir = dir;
        case (mode)
            MODE_FLOW_UP: begin
                if (!is_one_hot(led))      r.led = INIT_FLOW_UP;
                else if (led == 4'b1000)   r.led = 4'b0001;
                else                       r.led = led << 1;
            end
            MODE_FLOW_DOWN: begin
                if (!is_one_hot(led))      r.led = INIT_FLOW_DOWN;
                else if (led == 4'b0001)   r.led = 4'b1000;
                else                       r.led = led >> 1;
            end
            MODE_BLINK: begin
                r.led = ~led;
            end
            default: begin
                if (!is_one_hot(led)) begin
                    r.led = INIT_PINGPONG;
                    r.dir = DIR_UP;
                end else if (led == 4'b1000) begin
                    r.led = 4'b0100;
                    r.dir = DIR_DOWN;
                end else if (led == 4'b0001) begin
                    r.led = 4'b0010;
                    r.dir = DIR_UP;
                end else if (dir == DIR_DOWN) begin
                    r.led = led >> 1;
                end else begin
                    r.led = led << 1;
                end
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/led_mode_scheduler_if.sv
// Configuration handshake between software/top-level logic and the LED scheduler.
interface led_mode_scheduler_if #(
    parameter int CNT_W = 32
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [1:0]       cfg_mode;
    logic [CNT_W-1:0] cfg_period;

    modport master (
        output cfg_valid,
        output cfg_mode,
        output cfg_period,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_mode,
        input  cfg_period,
        output cfg_ready
    );
endinterface

// File: rtl/led_mode_scheduler_step_timer.sv
// Step-period counter: counts while enabled and flags the last clock of each period.
module led_step_timer #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [CNT_W-1:0] period,
    output logic             tick,
    output logic [CNT_W-1:0] cnt
);

    assign tick = (cnt == period - CNT_W'(1));

    // Wraps to zero on the tick so the next period starts immediately.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/led_mode_scheduler.sv
// Drives the LED bank through one of four patterns at a programmable step period,
// configured over a valid/ready handshake and started/paused by the run level.
module led_mode_scheduler #(
    parameter int          CNT_W      = 32,
    parameter int          LED_W      = 4,
    parameter int unsigned DEF_PERIOD = 50_000_000,
    parameter logic [1:0]  DEF_MODE   = 2'd0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    led_mode_scheduler_if.slave  cfg,
    input  logic                 run,
    output logic [LED_W-1:0]     led,
    output logic                 step_pulse,
    output logic                 busy
);
    import led_pkg::*;

    state_t           state_q;
    mode_t            mode_q;
    logic [CNT_W-1:0] period_q;
    led_t             led_q;
    logic             dir_q;
    logic             step_q;
    logic             busy_q;
    logic             ready_q;

    logic             xfer;
    logic             tick;
    logic             en;
    logic             clr;
    logic [CNT_W-1:0] step_cnt;
    mode_t            start_mode;
    step_t            nxt;

    assign xfer       = cfg.cfg_valid && ready_q;
    assign start_mode = xfer ? mode_t'(cfg.cfg_mode) : mode_q;
    assign nxt        = next_pattern(mode_q, led_q, dir_q);

    // Counter only advances while actually running; it is parked at zero whenever idle.
    assign en  = (state_q == ST_RUN) && run;
    assign clr = ((state_q == ST_PAUSE) && xfer) ||
                 ((state_q == ST_IDLE) && (step_cnt != '0));

    led_step_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .clr    (clr),
        .period (period_q),
        .tick   (tick),
        .cnt    (step_cnt)
    );

    assign led           = led_q;
    assign step_pulse    = step_q;
    assign busy          = busy_q;
    assign cfg.cfg_ready = ready_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            mode_q   <= mode_t'(DEF_MODE);
            period_q <= CNT_W'(DEF_PERIOD);
            led_q    <= '0;
            dir_q    <= DIR_UP;
            step_q   <= 1'b0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            step_q <= 1'b0;
            if (xfer) begin
                mode_q   <= mode_t'(cfg.cfg_mode);
                period_q <= (cfg.cfg_period == '0) ? CNT_W'(1) : cfg.cfg_period;
            end
            case (state_q)
                ST_IDLE: begin
                    led_q <= '0;
                    if (run) begin
                        state_q <= ST_RUN;
                        led_q   <= init_pattern(start_mode);
                        dir_q   <= DIR_UP;
                        busy_q  <= 1'b1;
                        ready_q <= 1'b0;
                    end
                end
                ST_RUN: begin
                    // Dropping run wins over a pending step in the same cycle.
                    if (!run) begin
                        state_q <= ST_PAUSE;
                        ready_q <= 1'b1;
                    end else if (tick) begin
                        led_q  <= nxt.led;
                        dir_q  <= nxt.dir;
                        step_q <= 1'b1;
                    end
                end
                ST_PAUSE: begin
                    if (xfer) begin
                        state_q <= ST_IDLE;
                        led_q   <= '0;
                        busy_q  <= 1'b0;
                    end else if (run) begin
                        state_q <= ST_RUN;
                        ready_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    led_q   <= '0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

endmodule
